// File: rtl/adder_result_checker.sv
// Result monitor for registered adder wrappers: delays the operands to line up
// with the wrapper output, compares against a + b, and keeps pass/fail statistics.
module adder_result_checker #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] res_sum,
    input  logic             res_cout,
    input  logic             clear,
    output logic             chk_valid,
    output logic             mismatch,
    output logic [CNT_W-1:0] check_count,
    output logic [CNT_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b,
    output logic [WIDTH:0]   first_err_got
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [LATENCY-1:0] dly_v;
    logic [WIDTH-1:0]   dly_a [LATENCY];
    logic [WIDTH-1:0]   dly_b [LATENCY];

    logic [WIDTH:0] exp_sum;
    logic [WIDTH:0] got;
    logic           do_check;
    logic           fail;

    // Only the valid bits are reset, so in-flight operations vanish on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_v <= '0;
        end else begin
            dly_v[0] <= op_valid;
            for (int k = 1; k < LATENCY; k++) begin
                dly_v[k] <= dly_v[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        dly_a[0] <= a;
        dly_b[0] <= b;
        for (int k = 1; k < LATENCY; k++) begin
            dly_a[k] <= dly_a[k-1];
            dly_b[k] <= dly_b[k-1];
        end
    end

    assign exp_sum  = {1'b0, dly_a[LATENCY-1]} + {1'b0, dly_b[LATENCY-1]};
    assign got      = {res_cout, res_sum};
    assign do_check = dly_v[LATENCY-1];
    assign fail     = do_check && (got != exp_sum);

    // The pulse outputs ignore clear: a comparison on a clearing edge is still reported
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_valid <= 1'b0;
            mismatch  <= 1'b0;
        end else begin
            chk_valid <= do_check;
            mismatch  <= fail;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            check_count <= '0;
            err_count   <= '0;
        end else if (do_check) begin
            if (check_count != CNT_MAX) begin
                check_count <= check_count + 1'b1;
            end
            if (fail && (err_count != CNT_MAX)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
            first_err_got   <= '0;
        end else if (fail && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_a     <= dly_a[LATENCY-1];
            first_err_b     <= dly_b[LATENCY-1];
            first_err_got   <= got;
        end
    end

endmodule

// File: tb/tb_adder_result_checker.sv
// Bench for adder_result_checker: a two-stage wrapper stand-in with fault injection,
// a queue-based model compared every cycle, and directed literal expectations.
module tb_adder_result_checker;

    localparam int WIDTH = 16;
    localparam int LAT   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              op_valid = 1'b0;
    logic [WIDTH-1:0]  a = '0;
    logic [WIDTH-1:0]  b = '0;
    logic              fault = 1'b0;
    logic              clear = 1'b0;
    logic [WIDTH-1:0]  res_sum;
    logic              res_cout;

    logic              chk_valid, mismatch, first_err_valid;
    logic [15:0]       check_count, err_count;
    logic [WIDTH-1:0]  first_err_a, first_err_b;
    logic [WIDTH:0]    first_err_got;

    logic              chk4, mis4, fev4;
    logic [3:0]        cc4, ec4;
    logic [WIDTH-1:0]  fa4, fb4;
    logic [WIDTH:0]    fg4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Wrapper stand-in: two register stages, optionally flipping the carry-out
    logic [WIDTH:0] w1, w2;
    always @(posedge clk) begin
        w1 <= ({1'b0, a} + {1'b0, b}) ^ (fault ? 17'h10000 : 17'h00000);
        w2 <= w1;
    end
    assign {res_cout, res_sum} = w2;

    adder_result_checker #(.WIDTH(WIDTH), .LATENCY(LAT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .a(a), .b(b),
        .res_sum(res_sum), .res_cout(res_cout), .clear(clear),
        .chk_valid(chk_valid), .mismatch(mismatch),
        .check_count(check_count), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_a(first_err_a),
        .first_err_b(first_err_b), .first_err_got(first_err_got)
    );

    adder_result_checker #(.WIDTH(WIDTH), .LATENCY(LAT), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .op_valid(op_valid), .a(a), .b(b),
        .res_sum(res_sum), .res_cout(res_cout), .clear(clear),
        .chk_valid(chk4), .mismatch(mis4),
        .check_count(cc4), .err_count(ec4),
        .first_err_valid(fev4), .first_err_a(fa4),
        .first_err_b(fb4), .first_err_got(fg4)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: operations wait in a queue until their due edge
    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             f;
        int               due;
    } op_t;

    op_t            q[$];
    op_t            cur;
    int             edge_n = 0;
    bit             ready = 0;
    logic           m_chk = 0, m_mis = 0, m_fev = 0;
    int             m_cc = 0, m_ec = 0, m_cc4 = 0, m_ec4 = 0;
    logic [WIDTH-1:0] m_fa = '0, m_fb = '0;
    logic [WIDTH:0] m_fg = '0, m_sum, m_got;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            q.delete();
            ready = 1;
            m_chk = 0; m_mis = 0; m_fev = 0;
            m_cc = 0; m_ec = 0; m_cc4 = 0; m_ec4 = 0;
            m_fa = '0; m_fb = '0; m_fg = '0;
        end else begin
            m_chk = 0;
            m_mis = 0;
            m_got = '0;
            if (q.size() > 0 && q[0].due == edge_n) begin
                cur   = q.pop_front();
                m_sum = {1'b0, cur.a} + {1'b0, cur.b};
                m_got = cur.f ? (m_sum ^ 17'h10000) : m_sum;
                m_chk = 1;
                m_mis = (m_got != m_sum);
            end
            if (clear) begin
                m_cc = 0; m_ec = 0; m_cc4 = 0; m_ec4 = 0;
                m_fev = 0; m_fa = '0; m_fb = '0; m_fg = '0;
            end else if (m_chk) begin
                if (m_cc < 65535) m_cc++;
                if (m_cc4 < 15) m_cc4++;
                if (m_mis) begin
                    if (m_ec < 65535) m_ec++;
                    if (m_ec4 < 15) m_ec4++;
                    if (!m_fev) begin
                        m_fev = 1; m_fa = cur.a; m_fb = cur.b; m_fg = m_got;
                    end
                end
            end
            if (op_valid) q.push_back('{a: a, b: b, f: fault, due: edge_n + LAT});
        end
    end

    always @(negedge clk) begin
        if (ready) begin
            check_output("chk_valid", {31'b0, chk_valid}, {31'b0, m_chk});
            check_output("mismatch", {31'b0, mismatch}, {31'b0, m_mis});
            check_output("check_count", {16'b0, check_count}, m_cc);
            check_output("err_count", {16'b0, err_count}, m_ec);
            check_output("first_err_valid", {31'b0, first_err_valid}, {31'b0, m_fev});
            check_output("first_err_a", {16'b0, first_err_a}, {16'b0, m_fa});
            check_output("first_err_b", {16'b0, first_err_b}, {16'b0, m_fb});
            check_output("first_err_got", {15'b0, first_err_got}, {15'b0, m_fg});
            check_output("cnt4_check_count", {28'b0, cc4}, m_cc4);
            check_output("cnt4_err_count", {28'b0, ec4}, m_ec4);
        end
    end

    // Inputs change 2 time units after an edge and are held across the next edge
    task automatic apply_stimulus(input logic v, input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                                  input logic f, input logic clr, input logic r);
        op_valid = v; a = ai; b = bi; fault = f; clear = clr; rst = r;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [4:0]       pat;
    logic [WIDTH-1:0] sat_a;

    initial begin
        // Reset with live traffic on the inputs
        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0, 1'b1);
        check_output("rst_chk_valid", {31'b0, chk_valid}, 32'd0);
        check_output("rst_mismatch", {31'b0, mismatch}, 32'd0);
        check_output("rst_counts", {check_count, err_count}, 32'd0);
        check_output("rst_first_err", {15'b0, first_err_valid, first_err_a}, 32'd0);
        check_output("rst_first_err_bg", {15'b0, first_err_b, first_err_got[16]}, 32'd0);

        // Passing op straight out of reset
        apply_stimulus(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        check_output("first_chk_early1", {31'b0, chk_valid}, 32'd0);
        idle(1);
        check_output("first_chk_early2", {31'b0, chk_valid}, 32'd0);
        idle(1);
        check_output("first_chk_on_time", {31'b0, chk_valid}, 32'd1);
        check_output("pass_mismatch", {31'b0, mismatch}, 32'd0);
        check_output("pass_count", {16'b0, check_count}, 32'd1);

        // Injected carry fault, then a second fault
        apply_stimulus(1'b1, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0);
        idle(2);
        check_output("fault_mismatch", {31'b0, mismatch}, 32'd1);
        check_output("fault_err_count", {16'b0, err_count}, 32'd1);
        check_output("fault_fev", {31'b0, first_err_valid}, 32'd1);
        check_output("fault_a", {16'b0, first_err_a}, 32'h0000FFFF);
        check_output("fault_b", {16'b0, first_err_b}, 32'h00000001);
        check_output("fault_got", {15'b0, first_err_got}, 32'h00000000);
        apply_stimulus(1'b1, 16'h1234, 16'h0F0F, 1'b1, 1'b0, 1'b0);
        idle(2);
        check_output("fault2_err_count", {16'b0, err_count}, 32'd2);
        check_output("fault2_a_kept", {16'b0, first_err_a}, 32'h0000FFFF);

        // Clear on the same edge as a failing comparison
        apply_stimulus(1'b1, 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0);
        idle(1);
        apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        check_output("clr_mismatch_seen", {31'b0, mismatch}, 32'd1);
        check_output("clr_counts", {check_count, err_count}, 32'd0);
        check_output("clr_fev", {31'b0, first_err_valid}, 32'd0);
        apply_stimulus(1'b1, 16'd5, 16'd6, 1'b0, 1'b0, 1'b0);
        idle(2);
        check_output("clr_after_count", {16'b0, check_count}, 32'd1);

        // Gapped traffic: chk_valid mirrors op_valid two applies later
        pat = 5'b01101;
        for (int i = 0; i < 7; i++) begin
            apply_stimulus((i < 5) ? pat[i] : 1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
            if (i >= 2) check_output("gap_chk_valid", {31'b0, chk_valid}, {31'b0, pat[i-2]});
        end
        check_output("gap_count", {16'b0, check_count}, 32'd4);

        // Back-to-back random passing stream
        apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 1000; i++)
            apply_stimulus(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
        idle(2);
        check_output("stream_count", {16'b0, check_count}, 32'd1000);
        check_output("stream_errs", {16'b0, err_count}, 32'd0);
        check_output("stream_cnt4_sat", {28'b0, cc4}, 32'd15);

        // Saturation of the narrow counters
        apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        sat_a = WIDTH'($urandom);
        apply_stimulus(1'b1, sat_a, 16'h0003, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 20; i++)
            apply_stimulus(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b1, 1'b0, 1'b0);
        idle(2);
        check_output("sat_err4", {28'b0, ec4}, 32'd15);
        check_output("sat_chk4", {28'b0, cc4}, 32'd15);
        check_output("sat_err16", {16'b0, err_count}, 32'd20);
        check_output("sat_first_a", {16'b0, first_err_a}, {16'b0, sat_a});

        // Reset with two operations in flight
        apply_stimulus(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check_output("mid_rst_counts", {check_count, err_count}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check_output("mid_rst_no_chk", {31'b0, chk_valid}, 32'd0);
        end
        check_output("mid_rst_count_after", {16'b0, check_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
